trace_packer: RTL
=================

TRACE_PACKER -- requirements
Module: trace_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: packed output word width, a power of two, at least MAX_TRACES.
REQ-002 SHALL have parameter MAX_TRACES, default 8: physical trace inputs, a power of two.
REQ-003 SHALL have parameter DELAY_WIDTH, default 16: width of the post-trigger word counter.
REQ-004 SHALL have ports CLK_I in 1 (sole clock) and RST_NI in 1 (reset); one clock, reset asynchronous and active-low.
REQ-005 SHALL have port CONF_UPDATE_I in 1: latches MODE_I, NTRACE_I and DELAY_I, and restarts the packer.
REQ-006 SHALL have ports MODE_I in 1 (0 trace, 1 stream), NTRACE_I in $clog2(MAX_TRACES)+1 (code k selects 2^k traces) and DELAY_I in DELAY_WIDTH (post-trigger words).
REQ-007 SHALL have ports ENABLE_I in 1 (sample enable), TRIG_I in 1 (trigger) and TRACE_I in MAX_TRACES (trace sample).
REQ-008 SHALL have output ports DATA_O WIDTH, EVENT_POS_O $clog2(WIDTH), TRG_EVENT_O 1 and VALID_O 1, plus input READY_I 1.
REQ-009 SHALL have output ports DONE_O 1 (capture finished, output drained) and OVERFLOW_O 1 (sticky word-drop flag).

Function
REQ-010 States SHALL be IDLE, ARMED, TRIGGERED and DONE.
REQ-011 Transitions: IDLE->ARMED on ENABLE_I; ARMED->TRIGGERED on the first sampled TRIG_I; TRIGGERED->DONE when trace mode has completed DELAY words after the trigger word.
REQ-012 The block SHALL sample only in ARMED/TRIGGERED with ENABLE_I=1; ENABLE_I=0 pauses the fill without loss, and TRIG_I is ignored when not sampling.
REQ-013 Active trace count n=2^k; k>log2(MAX_TRACES) SHALL clamp to MAX_TRACES; the block SHALL capture TRACE_I[n-1:0].
REQ-014 Packing SHALL be LSB-first: sample i occupies bits [(i+1)n-1 : i*n]; a word is complete after WIDTH/n samples, and the fill offset then wraps to 0.
REQ-015 A completed word SHALL load the output register and assert VALID_O on the next cycle (1-cycle latency).
REQ-016 VALID_O/READY_I handshake: a transfer occurs when both are high; VALID_O SHALL hold DATA_O stable until the transfer.
REQ-017 Word completion in the same cycle as a transfer SHALL load the new word with VALID_O held high (no bubble).
REQ-018 Word completion while VALID_O=1 and READY_I=0 SHALL drop the new word and set OVERFLOW_O until CONF_UPDATE_I or reset.
REQ-019 The word containing the trigger sample SHALL carry TRG_EVENT_O=1 and EVENT_POS_O = i*n; all other words SHALL carry TRG_EVENT_O=0 and EVENT_POS_O=0.
REQ-020 Only the first trigger per capture SHALL be recorded.
REQ-021 Trace mode: after the trigger word, exactly DELAY_I further words SHALL be produced, then state DONE; DELAY_I=0 SHALL stop after the trigger word.
REQ-022 Stream mode: the trigger SHALL be flagged but capture SHALL continue indefinitely; DELAY_I is ignored and DONE is unreachable.
REQ-023 DONE_O SHALL be 1 only in DONE with VALID_O=0; the partial word at stop SHALL be discarded.
REQ-024 CONF_UPDATE_I SHALL win over every simultaneous event: state IDLE, fill and counters cleared, output register emptied, OVERFLOW_O cleared, new configuration active from the next cycle.
REQ-025 The post-trigger counter SHALL count only produced (completed) words, including dropped ones.

Reset
REQ-026 While RST_NI=0 all outputs SHALL be 0 and the state IDLE, asynchronously.
REQ-027 Reset configuration SHALL be MODE=0, k=log2(MAX_TRACES), DELAY=0.
REQ-028 Reset release mid-capture SHALL restart in IDLE; no partial data survives.

Structure
REQ-029 DTB_PKG SHALL hold the trace_packer_state_t enum and the defaults TRB_WIDTH, TRB_MAX_TRACES and TRB_NTRACE_BITS.
REQ-030 The output register/handshake SHALL be the single sub-module trace_out_slot; packing and the FSM stay in trace_packer.

Verification (WIDTH=32, MAX_TRACES=8)
REQ-031 Assert RST_NI=0 mid-capture -> all outputs 0 immediately; after release, state IDLE.
REQ-032 k=3, enable, TRACE_I=01,02,03,04 -> DATA_O=32'h04030201 with VALID_O one cycle after the 4th sample.
REQ-033 Trace mode, k=0, DELAY=2, TRIG_I on 5th sample -> word0 TRG_EVENT_O=1, EVENT_POS_O=4; two more words follow, then DONE_O=1.
REQ-034 READY_I=0, two words complete -> first word held, second dropped, OVERFLOW_O=1; CONF_UPDATE_I clears it.
REQ-035 Stream mode, DELAY=1, trigger -> exactly one TRG_EVENT_O word, words continue past 5 more, DONE_O stays 0.
REQ-036 CONF_UPDATE_I with TRIG_I in the same cycle, mid-word -> VALID_O=0, state IDLE, no trigger recorded.

Source files
------------

// File: rtl/dtb_pkg.sv
// Shared types and default sizing for the trace packer.
// The capture FSM state type is used by the packer and by anything observing its debug state.
package dtb_pkg;

    localparam int TRB_WIDTH       = 32;
    localparam int TRB_MAX_TRACES  = 8;
    localparam int TRB_NTRACE_BITS = $clog2(TRB_MAX_TRACES) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        TRIGGERED = 2'd2,
        DONE      = 2'd3
    } trace_packer_state_t;

endpackage

// File: rtl/trace_out_slot.sv
// Single-entry output register for packed trace words with a sticky overflow flag.
// A word offered while the slot is still held (valid and not ready) is dropped.
module trace_out_slot #(
    parameter int WIDTH = 32,
    parameter int POS_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_trg,
    input  logic [POS_W-1:0] load_pos,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             trg,
    output logic [POS_W-1:0] pos,
    output logic             valid,
    output logic             overflow
);

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // while valid is high and no transfer has happened, data/trg/pos stay unchanged.
    // A load arriving in the transfer cycle replaces the word and keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            trg      <= 1'b0;
            pos      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            data     <= '0;
            trg      <= 1'b0;
            pos      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (load && valid && !ready) begin
            overflow <= 1'b1;
        end else if (load) begin
            data  <= load_data;
            trg   <= load_trg;
            pos   <= load_pos;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/trace_packer.sv
// Packs 2^k trace lanes per sample LSB-first into WIDTH-bit words, flags the trigger
// word, and in trace mode stops DELAY words after the trigger word.
module trace_packer import dtb_pkg::*; #(
    parameter int WIDTH       = TRB_WIDTH,
    parameter int MAX_TRACES  = TRB_MAX_TRACES,
    parameter int DELAY_WIDTH = 16
) (
    input  logic                          CLK_I,
    input  logic                          RST_NI,
    input  logic                          CONF_UPDATE_I,
    input  logic                          MODE_I,
    input  logic [$clog2(MAX_TRACES):0]   NTRACE_I,
    input  logic [DELAY_WIDTH-1:0]        DELAY_I,
    input  logic                          ENABLE_I,
    input  logic                          TRIG_I,
    input  logic [MAX_TRACES-1:0]         TRACE_I,
    output logic [WIDTH-1:0]              DATA_O,
    output logic [$clog2(WIDTH)-1:0]      EVENT_POS_O,
    output logic                          TRG_EVENT_O,
    output logic                          VALID_O,
    input  logic                          READY_I,
    output logic                          DONE_O,
    output logic                          OVERFLOW_O,
    output trace_packer_state_t           DBG_STATE_O
);

    localparam int KW      = $clog2(MAX_TRACES) + 1;
    localparam int LOG2_MT = $clog2(MAX_TRACES);
    localparam int POS_W   = $clog2(WIDTH);

    logic                   mode_q;
    logic [KW-1:0]          k_q;
    logic [DELAY_WIDTH-1:0] delay_q;
    trace_packer_state_t    state_q, state_d;
    logic [WIDTH-1:0]       fill_q;
    logic [POS_W-1:0]       off_q;
    logic                   trg_pend_q;
    logic [POS_W-1:0]       trg_pos_q;
    logic [DELAY_WIDTH-1:0] cnt_q;

    logic [KW-1:0]    k_eff;
    logic [POS_W:0]   n_act;
    logic [POS_W:0]   last_off;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] word_full;
    logic [POS_W-1:0] word_pos;
    logic             sampling, last_slot, trg_now, word_done, word_is_trg, cnt_inc, stop;

    always_comb begin
        k_eff     = (k_q > KW'(LOG2_MT)) ? KW'(LOG2_MT) : k_q;
        n_act     = (POS_W+1)'(1) << k_eff;
        last_off  = (POS_W+1)'(WIDTH) - n_act;
        lane_mask = (WIDTH'(1) << n_act) - WIDTH'(1);
        word_full = fill_q | ((WIDTH'(TRACE_I) & lane_mask) << off_q);
        sampling  = ENABLE_I && (state_q == ARMED || state_q == TRIGGERED);
        last_slot = ({1'b0, off_q} == last_off);
        trg_now   = sampling && (state_q == ARMED) && TRIG_I;
        word_done = sampling && last_slot;
        word_is_trg = trg_now || trg_pend_q;
        word_pos  = trg_now ? off_q : (trg_pend_q ? trg_pos_q : '0);
        // Post-trigger words are those completed after the trigger word, dropped or not.
        cnt_inc   = word_done && (state_q == TRIGGERED) && !word_is_trg;
        stop      = word_done && !mode_q &&
                    (word_is_trg ? (delay_q == '0)
                                 : (cnt_inc && (cnt_q + DELAY_WIDTH'(1) == delay_q)));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ENABLE_I) state_d = ARMED;
            ARMED:   if (trg_now) state_d = TRIGGERED;
            default: state_d = state_q;
        endcase
        if (stop) state_d = DONE;
        if (CONF_UPDATE_I) state_d = IDLE;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            mode_q     <= 1'b0;
            k_q        <= KW'(LOG2_MT);
            delay_q    <= '0;
            state_q    <= IDLE;
            fill_q     <= '0;
            off_q      <= '0;
            trg_pend_q <= 1'b0;
            trg_pos_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (CONF_UPDATE_I) begin
                mode_q     <= MODE_I;
                k_q        <= NTRACE_I;
                delay_q    <= DELAY_I;
                fill_q     <= '0;
                off_q      <= '0;
                trg_pend_q <= 1'b0;
                trg_pos_q  <= '0;
                cnt_q      <= '0;
            end else if (sampling) begin
                if (last_slot) begin
                    fill_q     <= '0;
                    off_q      <= '0;
                    trg_pend_q <= 1'b0;
                    trg_pos_q  <= '0;
                end else begin
                    fill_q <= word_full;
                    off_q  <= POS_W'({1'b0, off_q} + n_act);
                    if (trg_now) begin
                        trg_pend_q <= 1'b1;
                        trg_pos_q  <= off_q;
                    end
                end
                if (cnt_inc) cnt_q <= cnt_q + DELAY_WIDTH'(1);
            end
        end
    end

    trace_out_slot #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_slot (
        .clk       (CLK_I),
        .rst_n     (RST_NI),
        .clear     (CONF_UPDATE_I),
        .load      (word_done),
        .load_data (word_full),
        .load_trg  (word_is_trg),
        .load_pos  (word_pos),
        .ready     (READY_I),
        .data      (DATA_O),
        .trg       (TRG_EVENT_O),
        .pos       (EVENT_POS_O),
        .valid     (VALID_O),
        .overflow  (OVERFLOW_O)
    );

    assign DONE_O      = (state_q == DONE) && !VALID_O;
    assign DBG_STATE_O = state_q;

endmodule
